jenc_rle_encoder: RTL and testbench

- Consumes quantized coefficients from the quantizer, two per cycle, in zigzag order (q_cnt 0..31 → zigzag indices 2*q_cnt, 2*q_cnt+1).
- Produces JPEG entropy symbols for the downstream Huffman coder, one per cycle: DC difference, AC (run, size, amplitude), ZRL and EOB.
- Keeps per-component DC predictors and flags end of frame.

---
 rtl/jenc_rle_encoder_pkg.sv | 22 ++
 rtl/jenc_rle_encoder_if.sv | 34 +++
 rtl/jenc_rle_encoder_size_cat.sv | 23 ++
 rtl/jenc_rle_encoder.sv | 189 ++++++++++++++++++
 tb/tb_jenc_rle_encoder.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/jenc_rle_encoder_pkg.sv
// Shared types and constants for the JPEG run-length symbol encoder.
package jenc_rle_pkg;

   localparam int QW_DEF = 11;          // quantized coefficient width
   localparam int AW_DEF = QW_DEF + 1;  // amplitude width, holds a DC difference

   localparam logic [3:0] ZRL_RUN      = 4'd15;
   localparam logic [4:0] BLK_LAST_CNT = 5'd31;
   localparam int         NUM_COMP     = 3;

   // One entropy symbol as handed to the Huffman coder.
   typedef struct packed {
      logic              dc;
      logic [3:0]        run;
      logic [3:0]        size;
      logic [AW_DEF-1:0] amp;
      logic [1:0]        chroma;
      logic              eob_blk;
      logic              last;
   } sym_t;

endpackage

// File: rtl/jenc_rle_encoder_if.sv
// Coefficient-pair input and symbol output bundle of the RLE encoder.
interface jenc_rle_encoder_if #(
   parameter int QW = 11,
   parameter int AW = 12
);
   logic [1:0][QW-1:0] q;
   logic               q_valid;
   logic               q_hold;
   logic [4:0]         q_cnt;
   logic [1:0]         q_chroma;
   logic               q_last_mcu;

   logic               s_valid;
   logic               s_hold;
   logic               s_dc;
   logic [3:0]         s_run;
   logic [3:0]         s_size;
   logic [AW-1:0]      s_amp;
   logic [1:0]         s_chroma;
   logic               s_eob_blk;
   logic               s_last;

   // Environment side: quantizer plus Huffman coder.
   modport master (
      output q, q_valid, q_cnt, q_chroma, q_last_mcu, s_hold,
      input  q_hold, s_valid, s_dc, s_run, s_size, s_amp, s_chroma, s_eob_blk, s_last
   );

   // Encoder side.
   modport slave (
      input  q, q_valid, q_cnt, q_chroma, q_last_mcu, s_hold,
      output q_hold, s_valid, s_dc, s_run, s_size, s_amp, s_chroma, s_eob_blk, s_last
   );
endinterface

// File: rtl/jenc_rle_encoder_size_cat.sv
// Magnitude category and VLI amplitude bits of a signed value.
module jenc_size_cat #(
   parameter int AW = 12
) (
   input  logic signed [AW-1:0] val,
   output logic [3:0]           size,
   output logic [AW-1:0]        amp
);
   logic [AW-1:0] mag, vli, mask;

   // size = bit length of |val|; negative values are sent as val-1 masked to size bits
   always_comb begin
      mag  = val[AW-1] ? -val : val;
      size = '0;
      for (int i = 0; i < AW; i++)
         if (mag[i]) size = 4'(i + 1);
      vli  = val - {{(AW-1){1'b0}}, val[AW-1]};
      mask = '0;
      for (int i = 0; i < AW; i++)
         mask[i] = (i < int'(size));
      amp  = vli & mask;
   end
endmodule

// File: rtl/jenc_rle_encoder.sv
// JPEG run-length encoder: coefficient pairs in, DC/AC/ZRL/EOB symbols out.
import jenc_rle_pkg::*;

module jenc_rle_encoder #(
   parameter int QW = QW_DEF,
   parameter int AW = AW_DEF
) (
   input logic               clk,
   input logic               reset,
   jenc_rle_encoder_if.slave bus
);
   // held pair
   logic               busy, phase, phase_nx;
   logic [QW-1:0]      p_q0, p_q1;
   logic [4:0]         p_cnt;
   logic [1:0]         p_chroma;
   logic               p_last_mcu;
   logic [5:0]         run_q, run_nx, r1;
   logic [NUM_COMP-1:0][QW-1:0] pred;
   logic [QW-1:0]      pred_sel;

   sym_t               sym, out_q;
   logic               s_valid_q;
   logic               emit, done, eval1;
   logic               stall, adv, retire, accept;
   logic               is_dc, blk_end, frame_end, c0_nz, c1_nz;

   logic signed [AW-1:0] ac0, ac1, diff;
   logic [3:0]           sz0, sz1, szd;
   logic [AW-1:0]        amp0, amp1, ampd;

   assign stall  = s_valid_q & bus.s_hold;
   assign adv    = busy & ~stall;
   assign retire = adv & done;
   assign accept = bus.q_valid & ~bus.q_hold;
   assign bus.q_hold = busy & ~retire;

   assign is_dc     = (p_cnt == 5'd0);
   assign blk_end   = (p_cnt == BLK_LAST_CNT);
   assign frame_end = p_last_mcu & (p_chroma == 2'd2);
   assign c0_nz     = |p_q0;
   assign c1_nz     = |p_q1;

   assign ac0 = {{(AW-QW){p_q0[QW-1]}}, p_q0};
   assign ac1 = {{(AW-QW){p_q1[QW-1]}}, p_q1};

   // Predictor of the held component; reads as zero while the frame's last symbol is leaving
   always_comb begin
      case (p_chroma)
         2'd0:    pred_sel = pred[0];
         2'd1:    pred_sel = pred[1];
         2'd2:    pred_sel = pred[2];
         default: pred_sel = '0;
      endcase
      if (s_valid_q && out_q.last) pred_sel = '0;
   end

   assign diff = ac0 - {{(AW-QW){pred_sel[QW-1]}}, pred_sel};

   jenc_size_cat #(.AW(AW)) u_sc0 (.val(ac0),  .size(sz0), .amp(amp0));
   jenc_size_cat #(.AW(AW)) u_sc1 (.val(ac1),  .size(sz1), .amp(amp1));
   jenc_size_cat #(.AW(AW)) u_scd (.val(diff), .size(szd), .amp(ampd));

   // One engine step: a zero slot0 falls straight through to slot1 so a pair costs max(1,k) cycles
   always_comb begin
      sym        = '0;
      sym.chroma = p_chroma;
      emit       = 1'b0;
      done       = 1'b0;
      eval1      = 1'b0;
      run_nx     = run_q;
      phase_nx   = phase;
      r1         = run_q;
      if (!phase) begin
         if (is_dc || c0_nz) begin
            emit = 1'b1;
            if (!is_dc && run_q[5:4] != 2'd0) begin
               sym.run = ZRL_RUN;
               run_nx  = run_q - 6'd16;
            end else begin
               sym.dc   = is_dc;
               sym.run  = is_dc ? 4'd0 : run_q[3:0];
               sym.size = is_dc ? szd  : sz0;
               sym.amp  = is_dc ? ampd : amp0;
               run_nx   = 6'd0;
               phase_nx = 1'b1;
               // a zero slot1 mid-block just starts a run, no extra cycle needed
               if (!c1_nz && !blk_end) begin
                  run_nx = 6'd1;
                  done   = 1'b1;
               end
            end
         end else begin
            r1    = run_q + 6'd1;
            eval1 = 1'b1;
         end
      end else begin
         eval1 = 1'b1;
      end
      if (eval1) begin
         phase_nx = 1'b1;
         if (c1_nz) begin
            emit = 1'b1;
            if (r1[5:4] != 2'd0) begin
               sym.run = ZRL_RUN;
               run_nx  = r1 - 6'd16;
            end else begin
               sym.run     = r1[3:0];
               sym.size    = sz1;
               sym.amp     = amp1;
               sym.eob_blk = blk_end;
               sym.last    = blk_end & frame_end;
               run_nx      = 6'd0;
               done        = 1'b1;
            end
         end else if (blk_end) begin
            emit        = 1'b1;
            sym.eob_blk = 1'b1;
            sym.last    = frame_end;
            run_nx      = 6'd0;
            done        = 1'b1;
         end else begin
            run_nx = r1 + 6'd1;
            done   = 1'b1;
         end
      end
   end

   // Pair register and engine state; an accept restarts at slot0
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy       <= 1'b0;
         phase      <= 1'b0;
         run_q      <= '0;
         p_q0       <= '0;
         p_q1       <= '0;
         p_cnt      <= '0;
         p_chroma   <= '0;
         p_last_mcu <= 1'b0;
      end else begin
         if (adv) begin
            run_q <= run_nx;
            phase <= phase_nx;
         end
         if (accept) begin
            busy       <= 1'b1;
            phase      <= 1'b0;
            p_q0       <= bus.q[0];
            p_q1       <= bus.q[1];
            p_cnt      <= bus.q_cnt;
            p_chroma   <= bus.q_chroma;
            p_last_mcu <= bus.q_last_mcu;
         end else if (retire) begin
            busy <= 1'b0;
         end
      end
   end

   // DC predictors: cleared as the frame's last symbol leaves, updated when a DC symbol is formed
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pred <= '0;
      end else begin
         if (s_valid_q && !bus.s_hold && out_q.last) pred <= '0;
         if (adv && !phase && is_dc && p_chroma != 2'd3) pred[p_chroma] <= p_q0;
      end
   end

   // Symbol output register, frozen while downstream holds
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s_valid_q <= 1'b0;
         out_q     <= '0;
      end else if (!stall) begin
         s_valid_q <= adv & emit;
         out_q     <= sym;
      end
   end

   assign bus.s_valid   = s_valid_q;
   assign bus.s_dc      = out_q.dc;
   assign bus.s_run     = out_q.run;
   assign bus.s_size    = out_q.size;
   assign bus.s_amp     = out_q.amp;
   assign bus.s_chroma  = out_q.chroma;
   assign bus.s_eob_blk = out_q.eob_blk;
   assign bus.s_last    = out_q.last;

endmodule

// File: tb/tb_jenc_rle_encoder.sv
// Directed bench for jenc_rle_encoder with a block-level symbol scoreboard.
import jenc_rle_pkg::*;

module tb_jenc_rle_encoder;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   jenc_rle_encoder_if #(.QW(QW_DEF), .AW(AW_DEF)) bus ();
   jenc_rle_encoder #(.QW(QW_DEF), .AW(AW_DEF)) dut (.clk(clk), .reset(reset), .bus(bus));

   int   n_vec = 0;
   int   n_bad = 0;
   int   waits;
   int   blk [64];
   int   pred_m [3];
   sym_t sb [$];
   sym_t obs_m, exp_m;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // expected symbol from its raw value; size by bit length, amp as JPEG VLI
   task automatic push_sym(input bit dc, input int run, input int v, input int ch,
                           input bit eob, input bit lst);
      sym_t s;
      int   m, sz;
      m  = (v < 0) ? -v : v;
      sz = 0;
      while ((m >> sz) != 0) sz++;
      s.dc      = dc;
      s.run     = 4'(run);
      s.size    = 4'(sz);
      s.amp     = AW_DEF'(((v < 0) ? v - 1 : v) & ((1 << sz) - 1));
      s.chroma  = 2'(ch);
      s.eob_blk = eob;
      s.last    = lst;
      sb.push_back(s);
   endtask

   // reference encoding of the whole 64-coefficient block in blk[]
   task automatic model_block(input int ch, input bit lm);
      bit fe;
      int run;
      fe  = lm && (ch == 2);
      run = 0;
      push_sym(1'b1, 0, blk[0] - pred_m[ch], ch, 1'b0, 1'b0);
      pred_m[ch] = blk[0];
      for (int k = 1; k < 64; k++) begin
         if (blk[k] == 0) run++;
         else begin
            while (run >= 16) begin
               push_sym(1'b0, 15, 0, ch, 1'b0, 1'b0);
               run -= 16;
            end
            push_sym(1'b0, run, blk[k], ch, k == 63, (k == 63) && fe);
            run = 0;
         end
      end
      if (blk[63] == 0) push_sym(1'b0, 0, 0, ch, 1'b1, fe);
      if (fe) pred_m = '{0, 0, 0};
   endtask

   task automatic send_pairs(input int ch, input bit lm, input int first, input int last_p);
      for (int p = first; p <= last_p; p++) begin
         int w;
         bus.q[0]       = QW_DEF'(blk[2*p]);
         bus.q[1]       = QW_DEF'(blk[2*p+1]);
         bus.q_cnt      = 5'(p);
         bus.q_chroma   = 2'(ch);
         bus.q_last_mcu = lm;
         bus.q_valid    = 1'b1;
         w = 0;
         while (bus.q_hold && w < 200) begin
            @(negedge clk);
            w++;
         end
         waits += w;
         chk("q_accept", 32'(w < 200), 32'd1);
         @(posedge clk);
         @(negedge clk);
      end
      bus.q_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while ((sb.size() != 0 || bus.s_valid) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      #2;
      chk(tag, 32'(sb.size()), 32'd0);
   endtask

   task automatic clr_blk();
      for (int k = 0; k < 64; k++) blk[k] = 0;
   endtask

   initial begin
      reset          = 1'b1;
      bus.q          = '0;
      bus.q_valid    = 1'b0;
      bus.q_cnt      = '0;
      bus.q_chroma   = '0;
      bus.q_last_mcu = 1'b0;
      bus.s_hold     = 1'b0;
      pred_m         = '{0, 0, 0};
      repeat (2) @(negedge clk);
      chk("rst_s_valid", 32'(bus.s_valid), 32'd0);
      chk("rst_fields", 32'({bus.s_dc, bus.s_run, bus.s_size, bus.s_amp, bus.s_chroma,
                             bus.s_eob_blk, bus.s_last}), 32'd0);
      chk("rst_q_hold", 32'(bus.q_hold), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // scoreboard monitor: compare every symbol that transfers on the next edge
      fork
         forever begin
            @(negedge clk);
            #1;
            if (!reset && bus.s_valid && !bus.s_hold) begin
               obs_m = {bus.s_dc, bus.s_run, bus.s_size, bus.s_amp, bus.s_chroma,
                        bus.s_eob_blk, bus.s_last};
               if (sb.size() == 0) chk("sb_nonempty", 32'(sb.size()), 32'd1);
               else begin
                  exp_m = sb.pop_front();
                  chk("sym", 32'(obs_m), 32'(exp_m));
               end
            end
         end
      join_none

      // Y DC=50, all AC zero: DC + EOB, no backpressure at all
      clr_blk(); blk[0] = 50;
      model_block(0, 1'b0);
      waits = 0;
      send_pairs(0, 1'b0, 0, 31);
      chk("blk1_q_hold_waits", 32'(waits), 32'd0);

      // second Y (diff -10) and an independent Cb predictor (diff -3)
      clr_blk(); blk[0] = 40;
      model_block(0, 1'b0); send_pairs(0, 1'b0, 0, 31);
      clr_blk(); blk[0] = -3;
      model_block(1, 1'b0); send_pairs(1, 1'b0, 0, 31);

      // AC -1 at 1 and 7 at 20, with a 5-cycle downstream hold on the ZRL
      clr_blk(); blk[0] = 40; blk[1] = -1; blk[20] = 7;
      model_block(0, 1'b0);
      send_pairs(0, 1'b0, 0, 10);
      bus.s_hold = 1'b1;
      repeat (5) begin
         @(negedge clk);
         #1;
         chk("hold_s_valid", 32'(bus.s_valid), 32'd1);
         chk("hold_sym", 32'({bus.s_dc, bus.s_run, bus.s_size, bus.s_amp, bus.s_chroma,
                              bus.s_eob_blk, bus.s_last}), 32'(sb[0]));
         chk("hold_q_hold", 32'(bus.q_hold), 32'd1);
      end
      @(negedge clk);
      bus.s_hold = 1'b0;
      send_pairs(0, 1'b0, 11, 31);

      // coefficient 63 alone after 62 zeros, DC at its most negative
      clr_blk(); blk[0] = -1024; blk[63] = 1;
      model_block(0, 1'b0); send_pairs(0, 1'b0, 0, 31);

      // Cr block: both last coefficients at full AC range
      clr_blk(); blk[62] = -1023; blk[63] = 1023;
      model_block(2, 1'b0); send_pairs(2, 1'b0, 0, 31);
      drain("drain_a");

      // last MCU of a frame, then next frame Y DC=50 sees cleared predictors
      for (int c = 0; c < 3; c++) begin
         clr_blk(); blk[0] = 10 + c; blk[3] = 5;
         model_block(c, 1'b1); send_pairs(c, 1'b1, 0, 31);
      end
      clr_blk(); blk[0] = 50;
      model_block(0, 1'b0); send_pairs(0, 1'b0, 0, 31);
      drain("drain_frame");

      // async reset in the middle of a busy block
      clr_blk(); blk[0] = 20;
      for (int k = 1; k <= 10; k++) blk[k] = 3;
      model_block(0, 1'b0);
      send_pairs(0, 1'b0, 0, 3);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_s_valid", 32'(bus.s_valid), 32'd0);
      chk("mid_rst_q_hold", 32'(bus.q_hold), 32'd0);
      sb.delete();
      pred_m = '{0, 0, 0};
      @(negedge clk);
      #2 reset = 1'b0;
      @(negedge clk);
      clr_blk(); blk[0] = 50; blk[2] = -6;
      model_block(0, 1'b0); send_pairs(0, 1'b0, 0, 31);
      drain("drain_post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
